dragon_body: RTL and testbench
==============================

DRAGON_BODY -- requirements
Module: dragon_body

Interface
REQ-001 SHALL have parameter MAX_SEG, default 8, meaning number of body segment registers (2..15).
REQ-002 SHALL have parameter RESET_LEN, default 2, meaning body length loaded at reset (1..MAX_SEG).
REQ-003 SHALL have parameter RESET_HEAD, default 8'h77, meaning head tile {y,x} loaded at reset.
REQ-004 SHALL have the following ports; reset rst, synchronous, active-high; clock frame_clk:
- frame_clk  in  1  frame-rate clock.
- rst  in  1  synchronous active-high reset.
- move  in  1  one-cycle strobe: the head has stepped to head_location.
- head_location  in  8  new head tile {y[3:0], x[3:0]}.
- head_direction  in  3  new head facing; 0 up, 1 right, 2 down, 3 left, 4..7 reserved.
- grow  in  1  one-cycle pulse: sheep eaten.
- hurt  in  1  one-cycle pulse: dragon struck by player.
- player_location  in  8  player tile.
- seg_location  out  8*MAX_SEG  flat bus; segment i occupies bits [8i+7:8i]; segment 0 is nearest the head.
- seg_direction  out  3*MAX_SEG  facing of each segment.
- seg_valid  out  MAX_SEG  bit i set when i < body_length.
- body_length  out  4  current segment count.
- player_hit  out  1  registered; player on a valid segment.
- self_hit  out  1  registered; head on a valid segment.
- dead  out  1  body exhausted.

Function
REQ-005 SHALL hold internal head_q/dir_q, initialised to RESET_HEAD/0.
REQ-006 On move in RUN, SHALL shift: seg[0] <= {head_q, dir_q}, seg[i] <= seg[i-1], head_q <= head_location, dir_q <= head_direction, all in one cycle.
REQ-007 Segments at index >= body_length SHALL still shift, so tiles reappear correctly on growth.
REQ-008 grow SHALL set a grow_pending flag; on the next move, body_length SHALL increment and grow_pending SHALL clear.
REQ-009 body_length SHALL saturate at MAX_SEG; grow at MAX_SEG SHALL be discarded with no pending flag set.
REQ-010 hurt SHALL decrement body_length in the same cycle, independent of move.
REQ-011 hurt while body_length == 1 SHALL set body_length to 0 and enter DEAD.
REQ-012 grow and hurt in the same cycle SHALL cancel, leaving length and grow_pending unchanged.
REQ-013 move coincident with hurt SHALL shift first, then apply the decrement; the resulting length SHALL be old_length - 1 (+1 if grow_pending, which clears).
REQ-014 The FSM SHALL have states INIT, RUN and DEAD.
- INIT: one cycle after reset, writes every segment to {RESET_HEAD, 0}, then goes to RUN.
- RUN: normal operation.
- DEAD: dead = 1; move, grow and hurt are ignored; exit only by rst.
REQ-015 In INIT, move, grow and hurt SHALL be ignored.
REQ-016 player_hit SHALL be registered one cycle after any cycle in which player_location equals a valid segment's location or head_q.
REQ-017 self_hit SHALL be registered one cycle after a move whose head_location equals a valid segment location, evaluated post-shift.
REQ-018 Coordinate compare SHALL be a full 8-bit equality; there SHALL be no wrap-around arithmetic on tiles.
REQ-019 Reserved head_direction values SHALL be stored unmodified.

Reset
REQ-020 rst SHALL force, mid-operation included:
- state = INIT, body_length = RESET_LEN, grow_pending = 0;
- player_hit = 0, self_hit = 0, dead = 0;
- head_q = RESET_HEAD, dir_q = 0;
- all segments to {RESET_HEAD, 0}.
REQ-021 seg_valid SHALL reflect RESET_LEN from the first cycle after rst deasserts.

Configuration
REQ-022 With DRAGON_SELF_COLLISION_EN defined, self_hit SHALL behave per REQ-017, and self_hit SHALL drive the FSM to DEAD on the following cycle.
REQ-023 Without DRAGON_SELF_COLLISION_EN, self_hit SHALL be tied 0, the comparator logic SHALL be absent, and self_hit SHALL NOT affect the FSM.

Structure
REQ-024 A shared package SHALL hold the direction encodings, the FSM state encodings (INIT, RUN, DEAD) and the tile-coordinate width of 4.
REQ-025 The block SHALL use one sub-module, dragon_tile_match, that compares one tile against MAX_SEG masked segments and returns a hit bit; it SHALL be instantiated for player_hit and, when enabled, for self_hit.

Verification
REQ-026 Reset with defaults -> body_length = 2, seg_valid = 8'b0000_0011, all segments 8'h77, dead = 0.
REQ-027 Three moves to 8'h78, 8'h79, 8'h7A -> seg0 = 8'h79, seg1 = 8'h78, seg2 = 8'h77 (invalid).
REQ-028 grow, then a move -> body_length 2->3, seg_valid = 8'b0000_0111; grow pulse at length 8 -> length stays 8.
REQ-029 Simultaneous grow and hurt at length 3 -> length stays 3; hurt at length 1 -> length 0, dead = 1, and later moves leave segments frozen.
REQ-030 player_location = seg1 tile -> player_hit = 1 exactly one cycle later; the same tile on an invalid segment -> player_hit = 0.
REQ-031 With DRAGON_SELF_COLLISION_EN, a move onto seg0's tile -> self_hit = 1 next cycle and dead = 1 the cycle after; without the macro -> self_hit stays 0.

Source files
------------

// File: rtl/dragon_body_pkg.sv
// Shared encodings for the dragon body: tile/direction widths, facing codes and FSM states.
package dragon_body_pkg;

    localparam int TILE_W = 4;
    localparam int LOC_W  = 2 * TILE_W;
    localparam int DIR_W  = 3;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 3'd0,
        DIR_RIGHT = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

endpackage

// File: rtl/dragon_body_tile_match.sv
// dragon_tile_match: flags whether one tile equals any masked segment location (full 8-bit equality).
module dragon_tile_match
    import dragon_body_pkg::*;
#(
    parameter int MAX_SEG = 8
) (
    input  logic [LOC_W-1:0]         tile,
    input  logic [LOC_W*MAX_SEG-1:0] segs,
    input  logic [MAX_SEG-1:0]       mask,
    output logic                     hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < MAX_SEG; i++) begin
            if (mask[i] && (segs[LOC_W*i +: LOC_W] == tile)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dragon_body.sv
// Dragon body: segment shift register following the head, length control, hit detection.
// Optional head-on-body death enabled by defining DRAGON_SELF_COLLISION_EN.
module dragon_body
    import dragon_body_pkg::*;
#(
    parameter int         MAX_SEG    = 8,
    parameter int         RESET_LEN  = 2,
    parameter logic [7:0] RESET_HEAD = 8'h77
) (
    input  logic                     frame_clk,
    input  logic                     rst,
    input  logic                     move,
    input  logic [LOC_W-1:0]         head_location,
    input  logic [DIR_W-1:0]         head_direction,
    input  logic                     grow,
    input  logic                     hurt,
    input  logic [LOC_W-1:0]         player_location,
    output logic [LOC_W*MAX_SEG-1:0] seg_location,
    output logic [DIR_W*MAX_SEG-1:0] seg_direction,
    output logic [MAX_SEG-1:0]       seg_valid,
    output logic [3:0]               body_length,
    output logic                     player_hit,
    output logic                     self_hit,
    output logic                     dead
);

    localparam logic [3:0] MAX_LEN   = 4'(MAX_SEG);
    localparam logic [3:0] START_LEN = 4'(RESET_LEN);

    state_e           state_q, state_next;
    logic [3:0]       length_q, length_next;
    logic             pending_q, pending_next;
    logic             shift, init_fill;
    logic [LOC_W-1:0] head_q;
    logic [DIR_W-1:0] dir_q;
    logic [LOC_W-1:0] seg_loc_q [MAX_SEG];
    logic [DIR_W-1:0] seg_dir_q [MAX_SEG];
    logic             player_match, player_hit_q;

    always_ff @(posedge frame_clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            length_q  <= START_LEN;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_next;
            length_q  <= length_next;
            pending_q <= pending_next;
        end
    end

    // Move, grow and hurt resolve in order: pending growth on the shift, then hurt, then new grow request.
    always_comb begin
        state_next   = state_q;
        length_next  = length_q;
        pending_next = pending_q;
        shift        = 1'b0;
        init_fill    = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_fill  = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                shift = move;
                if (move && pending_q) begin
                    if (length_next < MAX_LEN) length_next = length_next + 4'd1;
                    pending_next = 1'b0;
                end
                if (hurt && !grow) begin
                    if (length_next <= 4'd1) begin
                        length_next = 4'd0;
                        state_next  = ST_DEAD;
                    end else begin
                        length_next = length_next - 4'd1;
                    end
                end
                if (grow && !hurt && (length_next < MAX_LEN)) begin
                    pending_next = 1'b1;
                end
`ifdef DRAGON_SELF_COLLISION_EN
                if (self_hit) state_next = ST_DEAD;
`endif
            end
            ST_DEAD: begin
                state_next = ST_DEAD;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (rst) begin
            head_q <= RESET_HEAD;
            dir_q  <= DIR_UP;
        end else if (shift) begin
            head_q <= head_location;
            dir_q  <= head_direction;
        end
    end

    // Segments beyond body_length keep shifting so grown segments land on real trail tiles.
    always_ff @(posedge frame_clk) begin
        if (rst || init_fill) begin
            for (int i = 0; i < MAX_SEG; i++) begin
                seg_loc_q[i] <= RESET_HEAD;
                seg_dir_q[i] <= DIR_UP;
            end
        end else if (shift) begin
            seg_loc_q[0] <= head_q;
            seg_dir_q[0] <= dir_q;
            for (int i = 1; i < MAX_SEG; i++) begin
                seg_loc_q[i] <= seg_loc_q[i-1];
                seg_dir_q[i] <= seg_dir_q[i-1];
            end
        end
    end

    for (genvar i = 0; i < MAX_SEG; i++) begin : g_out
        assign seg_location[LOC_W*i +: LOC_W]  = seg_loc_q[i];
        assign seg_direction[DIR_W*i +: DIR_W] = seg_dir_q[i];
        assign seg_valid[i]                    = (4'(i) < length_q);
    end

    assign body_length = length_q;
    assign dead        = (state_q == ST_DEAD);

    logic player_seg_match;

    dragon_tile_match #(.MAX_SEG(MAX_SEG)) u_player_match (
        .tile (player_location),
        .segs (seg_location),
        .mask (seg_valid),
        .hit  (player_seg_match)
    );

    assign player_match = player_seg_match || (player_location == head_q);

    always_ff @(posedge frame_clk) begin
        if (rst) player_hit_q <= 1'b0;
        else     player_hit_q <= player_match;
    end

    assign player_hit = player_hit_q;

`ifdef DRAGON_SELF_COLLISION_EN
    // Compare the new head against the body as it will look after this move's shift.
    logic [LOC_W*MAX_SEG-1:0] shifted_loc;
    logic                     self_match, self_hit_q;

    assign shifted_loc[LOC_W-1:0] = head_q;
    for (genvar i = 1; i < MAX_SEG; i++) begin : g_shifted
        assign shifted_loc[LOC_W*i +: LOC_W] = seg_loc_q[i-1];
    end

    dragon_tile_match #(.MAX_SEG(MAX_SEG)) u_self_match (
        .tile (head_location),
        .segs (shifted_loc),
        .mask (seg_valid),
        .hit  (self_match)
    );

    always_ff @(posedge frame_clk) begin
        if (rst) self_hit_q <= 1'b0;
        else     self_hit_q <= (state_q == ST_RUN) && move && self_match;
    end

    assign self_hit = self_hit_q;
`else
    assign self_hit = 1'b0;
`endif

endmodule

// File: tb/tb_dragon_body.sv
// Directed bench for dragon_body: reset, shifting, growth/hurt rules, hit flags and death.
module tb_dragon_body;

    logic        frame_clk = 1'b0;
    logic        rst = 1'b1;
    logic        move = 1'b0;
    logic [7:0]  head_location = 8'h00;
    logic [2:0]  head_direction = 3'd0;
    logic        grow = 1'b0;
    logic        hurt = 1'b0;
    logic [7:0]  player_location = 8'h00;
    logic [63:0] seg_location;
    logic [23:0] seg_direction;
    logic [7:0]  seg_valid;
    logic [3:0]  body_length;
    logic        player_hit;
    logic        self_hit;
    logic        dead;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_loc [8];
    logic [2:0] m_dir [8];
    logic [7:0] m_head;
    logic [2:0] m_hdir;

    always #5 frame_clk = ~frame_clk;

    dragon_body dut (
        .frame_clk       (frame_clk),
        .rst             (rst),
        .move            (move),
        .head_location   (head_location),
        .head_direction  (head_direction),
        .grow            (grow),
        .hurt            (hurt),
        .player_location (player_location),
        .seg_location    (seg_location),
        .seg_direction   (seg_direction),
        .seg_valid       (seg_valid),
        .body_length     (body_length),
        .player_hit      (player_hit),
        .self_hit        (self_hit),
        .dead            (dead)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_loc[i] = 8'h77;
            m_dir[i] = 3'd0;
        end
        m_head = 8'h77;
        m_hdir = 3'd0;
    endtask

    function automatic logic [63:0] model_loc_bus();
        logic [63:0] b;
        for (int i = 0; i < 8; i++) b[8*i +: 8] = m_loc[i];
        return b;
    endfunction

    function automatic logic [23:0] model_dir_bus();
        logic [23:0] b;
        for (int i = 0; i < 8; i++) b[3*i +: 3] = m_dir[i];
        return b;
    endfunction

    task automatic do_move(input logic [7:0] loc, input logic [2:0] dir, input bit expect_shift);
        head_location  = loc;
        head_direction = dir;
        move = 1'b1;
        tick();
        move = 1'b0;
        if (expect_shift) begin
            for (int i = 7; i > 0; i--) begin
                m_loc[i] = m_loc[i-1];
                m_dir[i] = m_dir[i-1];
            end
            m_loc[0] = m_head;
            m_dir[0] = m_hdir;
            m_head   = loc;
            m_hdir   = dir;
        end
    endtask

    task automatic pulse_grow();
        grow = 1'b1;
        tick();
        grow = 1'b0;
    endtask

    task automatic pulse_hurt();
        hurt = 1'b1;
        tick();
        hurt = 1'b0;
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_len", 64'(body_length), 64'd2);
        chk("rst_valid", 64'(seg_valid), 64'h03);
        chk("rst_dead", 64'(dead), 64'd0);
        chk("rst_phit", 64'(player_hit), 64'd0);
        tick();
        chk("init_segs", seg_location, 64'h7777_7777_7777_7777);
        chk("init_dirs", 64'(seg_direction), 64'd0);

        do_move(8'h78, 3'd1, 1'b1);
        do_move(8'h79, 3'd1, 1'b1);
        do_move(8'h7A, 3'd1, 1'b1);
        chk("shift3_seg0", 64'(seg_location[7:0]), 64'h79);
        chk("shift3_seg1", 64'(seg_location[15:8]), 64'h78);
        chk("shift3_seg2", 64'(seg_location[23:16]), 64'h77);
        chk("shift3_bus", seg_location, model_loc_bus());
        chk("shift3_dirs", 64'(seg_direction), 64'(model_dir_bus()));
        chk("shift3_valid", 64'(seg_valid), 64'h03);

        pulse_grow();
        chk("grow_wait_len", 64'(body_length), 64'd2);
        do_move(8'h7B, 3'd2, 1'b1);
        chk("grow_len", 64'(body_length), 64'd3);
        chk("grow_valid", 64'(seg_valid), 64'h07);
        chk("grow_bus", seg_location, model_loc_bus());

        grow = 1'b1;
        hurt = 1'b1;
        tick();
        grow = 1'b0;
        hurt = 1'b0;
        chk("cancel_len", 64'(body_length), 64'd3);
        do_move(8'h7C, 3'd2, 1'b1);
        chk("cancel_no_pend", 64'(body_length), 64'd3);

        do_move(8'h7D, 3'd7, 1'b1);
        do_move(8'h7E, 3'd0, 1'b1);
        chk("resv_dir", 64'(seg_direction[2:0]), 64'd7);
        chk("resv_bus", seg_location, model_loc_bus());

        player_location = 8'h7C;
        chk("phit_before", 64'(player_hit), 64'd0);
        tick();
        chk("phit_seg1", 64'(player_hit), 64'd1);
        player_location = 8'h7A;
        tick();
        chk("phit_invalid", 64'(player_hit), 64'd0);
        player_location = 8'h7E;
        tick();
        chk("phit_head", 64'(player_hit), 64'd1);
        player_location = 8'h00;
        tick();

        pulse_grow();
        hurt = 1'b1;
        do_move(8'h6E, 3'd3, 1'b1);
        hurt = 1'b0;
        chk("move_hurt_len", 64'(body_length), 64'd3);

        for (int k = 0; k < 5; k++) begin
            pulse_grow();
            do_move(8'h50 + 8'(k), 3'(k), 1'b1);
        end
        chk("sat_len", 64'(body_length), 64'd8);
        pulse_grow();
        do_move(8'h60, 3'd1, 1'b1);
        chk("sat_hold", 64'(body_length), 64'd8);
        chk("sat_valid", 64'(seg_valid), 64'hFF);
        pulse_hurt();
        do_move(8'h61, 3'd2, 1'b1);
        chk("sat_no_pend", 64'(body_length), 64'd7);
        chk("sat_bus", seg_location, model_loc_bus());

        for (int k = 0; k < 6; k++) pulse_hurt();
        chk("len_one", 64'(body_length), 64'd1);
        chk("len_one_alive", 64'(dead), 64'd0);
        pulse_hurt();
        chk("dead_len", 64'(body_length), 64'd0);
        chk("dead_flag", 64'(dead), 64'd1);
        chk("dead_valid", 64'(seg_valid), 64'd0);
        do_move(8'h62, 3'd3, 1'b0);
        pulse_grow();
        chk("dead_frozen", seg_location, model_loc_bus());
        chk("dead_len_hold", 64'(body_length), 64'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("rerst_len", 64'(body_length), 64'd2);
        chk("rerst_dead", 64'(dead), 64'd0);
        tick();
        chk("rerst_segs", seg_location, 64'h7777_7777_7777_7777);

        do_move(8'h77, 3'd0, 1'b1);
`ifdef DRAGON_SELF_COLLISION_EN
        chk("self_hit", 64'(self_hit), 64'd1);
        chk("self_not_dead_yet", 64'(dead), 64'd0);
        tick();
        chk("self_dead", 64'(dead), 64'd1);
`else
        chk("self_hit_off", 64'(self_hit), 64'd0);
        tick();
        chk("self_alive", 64'(dead), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
